// File: rtl/sc_motor_select_ramp_pkg.sv
// Shared encodings for the motor select/ramp stage: select bus values from the
// behaviour FSM and the per-wheel ramp state codes.
package sc_motor_select_ramp_pkg;

    localparam logic [1:0] SEL_INIT_STOP = 2'b00;
    localparam logic [1:0] SEL_POS       = 2'b01;
    localparam logic [1:0] SEL_AVOID     = 2'b10;
    localparam logic [1:0] SEL_HARD_STOP = 2'b11;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_BRAKE = 2'd1;
    localparam logic [1:0] ST_DEAD  = 2'd2;

endpackage

// File: rtl/sc_motor_select_ramp_if.sv
// Select bus, controller duty/direction sources and ramped wheel outputs.
interface sc_motor_select_ramp_if #(
    parameter int DUTY_W = 8
);
    logic [1:0]        sel_in;
    logic [DUTY_W-1:0] pos_left_duty;
    logic [DUTY_W-1:0] pos_right_duty;
    logic              pos_left_dir;
    logic              pos_right_dir;
    logic [DUTY_W-1:0] avoid_left_duty;
    logic [DUTY_W-1:0] avoid_right_duty;
    logic              avoid_left_dir;
    logic              avoid_right_dir;
    logic [DUTY_W-1:0] left_duty_out;
    logic [DUTY_W-1:0] right_duty_out;
    logic              left_dir_out;
    logic              right_dir_out;
    logic              settled_out;
    logic              hard_stop_out;

    modport master (
        output sel_in, pos_left_duty, pos_right_duty, pos_left_dir, pos_right_dir,
               avoid_left_duty, avoid_right_duty, avoid_left_dir, avoid_right_dir,
        input  left_duty_out, right_duty_out, left_dir_out, right_dir_out,
               settled_out, hard_stop_out
    );

    modport slave (
        input  sel_in, pos_left_duty, pos_right_duty, pos_left_dir, pos_right_dir,
               avoid_left_duty, avoid_right_duty, avoid_left_dir, avoid_right_dir,
        output left_duty_out, right_duty_out, left_dir_out, right_dir_out,
               settled_out, hard_stop_out
    );
endinterface

// File: rtl/sc_motor_select_ramp_wheel.sv
// One wheel: slew-limited duty toward target, with brake-to-zero and a
// dead-time window before the applied direction is allowed to flip.
module sc_wheel_ramp
    import sc_motor_select_ramp_pkg::*;
#(
    parameter int DUTY_W       = 8,
    parameter int STEP         = 4,
    parameter int DEADTIME_CYC = 2500
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_tick,
    input  logic              i_hard_stop,
    input  logic [DUTY_W-1:0] i_target_duty,
    input  logic              i_target_dir,
    output logic [DUTY_W-1:0] o_duty,
    output logic              o_dir,
    output logic              o_at_target
);
    localparam int CNT_W = (DEADTIME_CYC > 1) ? $clog2(DEADTIME_CYC) : 1;
    localparam logic [DUTY_W:0]   STEP_X   = (DUTY_W+1)'(STEP);
    localparam logic [DUTY_W-1:0] STEP_N   = DUTY_W'(STEP);
    localparam logic [CNT_W-1:0]  DEAD_LD  = CNT_W'(DEADTIME_CYC - 1);

    logic [DUTY_W-1:0] r_duty;
    logic              r_dir;
    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_dead_cnt;

    logic [DUTY_W:0]   w_up;
    logic [DUTY_W-1:0] w_next_run;
    logic [DUTY_W-1:0] w_next_brake;

    // Widened sums so an up-step near full scale cannot wrap before clamping.
    assign w_up = {1'b0, r_duty} + STEP_X;

    always_comb begin
        w_next_run = r_duty;
        if (r_duty < i_target_duty)
            w_next_run = (w_up > {1'b0, i_target_duty}) ? i_target_duty : w_up[DUTY_W-1:0];
        else if (r_duty > i_target_duty)
            w_next_run = (({1'b0, r_duty} - {1'b0, i_target_duty}) > STEP_X) ?
                         (r_duty - STEP_N) : i_target_duty;
    end

    assign w_next_brake = ({1'b0, r_duty} > STEP_X) ? (r_duty - STEP_N) : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_duty     <= '0;
            r_dir      <= 1'b0;
            r_state    <= ST_RUN;
            r_dead_cnt <= '0;
        end else if (i_hard_stop) begin
            r_duty     <= '0;
            r_state    <= ST_RUN;
            r_dead_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_target_dir != r_dir) r_state <= ST_BRAKE;
                    else if (i_tick)           r_duty  <= w_next_run;
                end
                ST_BRAKE: begin
                    if (i_target_dir == r_dir) begin
                        r_state <= ST_RUN;
                    end else if (r_duty == '0) begin
                        r_dead_cnt <= DEAD_LD;
                        r_state    <= ST_DEAD;
                    end else if (i_tick) begin
                        r_duty <= w_next_brake;
                    end
                end
                ST_DEAD: begin
                    r_duty <= '0;
                    if (r_dead_cnt == '0) begin
                        r_dir   <= i_target_dir;
                        r_state <= ST_RUN;
                    end else begin
                        r_dead_cnt <= r_dead_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign o_duty      = r_duty;
    assign o_dir       = r_dir;
    assign o_at_target = (r_state == ST_RUN) && (r_duty == i_target_duty) && (r_dir == i_target_dir);

endmodule

// File: rtl/sc_motor_select_ramp.sv
// Select-bus consumer: registers the behaviour FSM select, picks per-wheel
// targets, and drives both wheel ramps from one shared free-running prescaler.
module sc_motor_select_ramp
    import sc_motor_select_ramp_pkg::*;
#(
    parameter int DUTY_W       = 8,
    parameter int RAMP_DIV     = 5000,
    parameter int STEP         = 4,
    parameter int DEADTIME_CYC = 2500
) (
    input  logic                    SC_STATEMACHINE_MUX41_CLOCK_50,
    input  logic                    SC_STATEMACHINE_MUX41_RESET_InHigh,
    sc_motor_select_ramp_if.slave   io_bus
);
    localparam int PW = $clog2(RAMP_DIV);
    localparam logic [PW-1:0] PRESC_TOP = PW'(RAMP_DIV - 1);

    logic [1:0]        r_sel;
    logic [PW-1:0]     r_presc;
    logic              r_settled;
    logic              r_hard_stop;

    logic              w_tick;
    logic              w_hard;
    logic [DUTY_W-1:0] w_tgt_l_duty, w_tgt_r_duty;
    logic              w_tgt_l_dir, w_tgt_r_dir;
    logic [DUTY_W-1:0] w_l_duty, w_r_duty;
    logic              w_l_dir, w_r_dir;
    logic              w_l_at, w_r_at;

    assign w_tick = (r_presc == PRESC_TOP);
    assign w_hard = (r_sel == SEL_HARD_STOP);

    always_ff @(posedge SC_STATEMACHINE_MUX41_CLOCK_50 or posedge SC_STATEMACHINE_MUX41_RESET_InHigh) begin
        if (SC_STATEMACHINE_MUX41_RESET_InHigh) begin
            r_sel       <= SEL_INIT_STOP;
            r_presc     <= '0;
            r_settled   <= 1'b0;
            r_hard_stop <= 1'b0;
        end else begin
            r_sel       <= io_bus.sel_in;
            r_presc     <= w_tick ? '0 : r_presc + 1'b1;
            r_settled   <= w_l_at && w_r_at && !w_hard;
            r_hard_stop <= w_hard;
        end
    end

    // Stop selections hold the applied direction so they never trigger a reversal.
    always_comb begin
        w_tgt_l_duty = '0;
        w_tgt_r_duty = '0;
        w_tgt_l_dir  = w_l_dir;
        w_tgt_r_dir  = w_r_dir;
        case (r_sel)
            SEL_POS: begin
                w_tgt_l_duty = io_bus.pos_left_duty;
                w_tgt_r_duty = io_bus.pos_right_duty;
                w_tgt_l_dir  = io_bus.pos_left_dir;
                w_tgt_r_dir  = io_bus.pos_right_dir;
            end
            SEL_AVOID: begin
                w_tgt_l_duty = io_bus.avoid_left_duty;
                w_tgt_r_duty = io_bus.avoid_right_duty;
                w_tgt_l_dir  = io_bus.avoid_left_dir;
                w_tgt_r_dir  = io_bus.avoid_right_dir;
            end
            default: ;
        endcase
    end

    sc_wheel_ramp #(.DUTY_W(DUTY_W), .STEP(STEP), .DEADTIME_CYC(DEADTIME_CYC)) u_left (
        .i_clk(SC_STATEMACHINE_MUX41_CLOCK_50), .i_rst(SC_STATEMACHINE_MUX41_RESET_InHigh),
        .i_tick(w_tick), .i_hard_stop(w_hard),
        .i_target_duty(w_tgt_l_duty), .i_target_dir(w_tgt_l_dir),
        .o_duty(w_l_duty), .o_dir(w_l_dir), .o_at_target(w_l_at)
    );

    sc_wheel_ramp #(.DUTY_W(DUTY_W), .STEP(STEP), .DEADTIME_CYC(DEADTIME_CYC)) u_right (
        .i_clk(SC_STATEMACHINE_MUX41_CLOCK_50), .i_rst(SC_STATEMACHINE_MUX41_RESET_InHigh),
        .i_tick(w_tick), .i_hard_stop(w_hard),
        .i_target_duty(w_tgt_r_duty), .i_target_dir(w_tgt_r_dir),
        .o_duty(w_r_duty), .o_dir(w_r_dir), .o_at_target(w_r_at)
    );

    assign io_bus.left_duty_out  = w_l_duty;
    assign io_bus.right_duty_out = w_r_duty;
    assign io_bus.left_dir_out   = w_l_dir;
    assign io_bus.right_dir_out  = w_r_dir;
    assign io_bus.settled_out    = r_settled;
    assign io_bus.hard_stop_out  = r_hard_stop;

endmodule

// File: tb/tb_sc_motor_select_ramp.sv
// Directed bench for sc_motor_select_ramp with RAMP_DIV=4, STEP=10, DEADTIME_CYC=3.
module tb_sc_motor_select_ramp;
    localparam int DUTY_W = 8;
    localparam int RAMP_DIV = 4;
    localparam int STEP = 10;
    localparam int DEADTIME_CYC = 3;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    always #10 clk = ~clk;

    sc_motor_select_ramp_if #(.DUTY_W(DUTY_W)) bus ();

    sc_motor_select_ramp #(.DUTY_W(DUTY_W), .RAMP_DIV(RAMP_DIV), .STEP(STEP), .DEADTIME_CYC(DEADTIME_CYC)) dut (
        .SC_STATEMACHINE_MUX41_CLOCK_50(clk),
        .SC_STATEMACHINE_MUX41_RESET_InHigh(rst),
        .io_bus(bus)
    );

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance until left duty changes; n returns the clocks taken.
    task automatic wait_left(input string tag, output int n);
        int prev;
        prev = int'(bus.left_duty_out);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (int'(bus.left_duty_out) == prev && n < 3*RAMP_DIV);
        vectors++;
        assert (int'(bus.left_duty_out) != prev) else begin
            miscompares++;
            $error("FAIL %s: no left duty change in %0d clocks, observed %0d", tag, n, prev);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        bus.sel_in = 2'b00;
        bus.pos_left_duty = '0;   bus.pos_right_duty = '0;
        bus.pos_left_dir = 1'b0;  bus.pos_right_dir = 1'b0;
        bus.avoid_left_duty = '0; bus.avoid_right_duty = '0;
        bus.avoid_left_dir = 1'b0; bus.avoid_right_dir = 1'b0;

        // Reset and idle stop
        step(2);
        chk("rst_lduty", bus.left_duty_out, 0);
        chk("rst_hs", bus.hard_stop_out, 0);
        chk("rst_settled", bus.settled_out, 0);
        rst = 1'b0;
        step(3);
        chk("idle_settled", bus.settled_out, 1);
        chk("idle_hs", bus.hard_stop_out, 0);
        chk("idle_rduty", bus.right_duty_out, 0);
        chk("idle_ldir", bus.left_dir_out, 0);

        // Ramp up to position targets
        bus.pos_left_duty = 8'd100; bus.pos_right_duty = 8'd95;
        bus.sel_in = 2'b01;
        for (int k = 1; k <= 10; k++) begin
            wait_left("up_wait", n);
            chk("up_left", bus.left_duty_out, (k*10 > 100) ? 100 : k*10);
            chk("up_right", bus.right_duty_out, (k*10 > 95) ? 95 : k*10);
            if (k > 1) chk("up_gap", n, RAMP_DIV);
        end
        step(2);
        chk("up_settled", bus.settled_out, 1);

        // Reversal via avoidance: brake, dead time, flip, ramp
        bus.avoid_left_duty = 8'd30; bus.avoid_left_dir = 1'b1;
        bus.avoid_right_duty = 8'd95; bus.avoid_right_dir = 1'b0;
        bus.sel_in = 2'b10;
        for (int k = 1; k <= 10; k++) begin
            wait_left("brk_wait", n);
            chk("brk_left", bus.left_duty_out, 100 - 10*k);
            chk("brk_ldir", bus.left_dir_out, 0);
        end
        step(3);
        chk("dead_ldir", bus.left_dir_out, 0);
        chk("dead_settled", bus.settled_out, 0);
        step(1);
        chk("flip_ldir", bus.left_dir_out, 1);
        for (int k = 1; k <= 3; k++) begin
            wait_left("rev_wait", n);
            chk("rev_left", bus.left_duty_out, 10*k);
        end
        chk("rev_ldir", bus.left_dir_out, 1);
        chk("rev_right", bus.right_duty_out, 95);

        // Run at 80 then hard stop
        bus.pos_left_duty = 8'd80; bus.pos_left_dir = 1'b1;
        bus.sel_in = 2'b01;
        for (int k = 4; k <= 8; k++) begin
            wait_left("to80_wait", n);
            chk("to80_left", bus.left_duty_out, 10*k);
        end
        bus.sel_in = 2'b11;
        step(1);
        chk("hs1_left", bus.left_duty_out, 80);
        chk("hs1_hs", bus.hard_stop_out, 0);
        step(1);
        chk("hs2_left", bus.left_duty_out, 0);
        chk("hs2_right", bus.right_duty_out, 0);
        chk("hs2_hs", bus.hard_stop_out, 1);
        chk("hs2_ldir", bus.left_dir_out, 1);
        chk("hs2_rdir", bus.right_dir_out, 0);
        chk("hs2_settled", bus.settled_out, 0);
        bus.pos_left_duty = 8'd100;
        step(5);
        chk("hs_hold", bus.left_duty_out, 0);

        // Release and ramp from 0; target drop mid-ramp
        bus.sel_in = 2'b01;
        wait_left("rel_wait", n);
        chk("rel_left", bus.left_duty_out, 10);
        chk("rel_right", bus.right_duty_out, 10);
        for (int k = 2; k <= 7; k++) begin
            wait_left("rel_up_wait", n);
            chk("rel_up", bus.left_duty_out, 10*k);
        end
        bus.pos_left_duty = 8'd50;
        wait_left("drop_wait", n);
        chk("drop_60", bus.left_duty_out, 60);
        wait_left("drop_wait", n);
        chk("drop_50", bus.left_duty_out, 50);
        step(3*RAMP_DIV);
        chk("drop_hold", bus.left_duty_out, 50);

        // Reset during dead time
        bus.pos_left_dir = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            wait_left("rd_wait", n);
            chk("rd_brake", bus.left_duty_out, 50 - 10*k);
        end
        step(2);
        chk("rd_pre_ldir", bus.left_dir_out, 1);
        #3 rst = 1'b1;
        #1;
        chk("rd_async_ldir", bus.left_dir_out, 0);
        chk("rd_async_rduty", bus.right_duty_out, 0);
        chk("rd_async_settled", bus.settled_out, 0);
        @(posedge clk); #1;
        bus.pos_left_duty = 8'd20;
        rst = 1'b0;
        step(3);
        chk("post_rst_l0", bus.left_duty_out, 0);
        step(1);
        chk("post_rst_l10", bus.left_duty_out, 10);
        chk("post_rst_r10", bus.right_duty_out, 10);
        chk("post_rst_ldir", bus.left_dir_out, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
